mux_2to1: RTL and testbench
===========================

Name: mux_2to1

Overview:
- Registered 32-bit 2:1 data selector used in the ROM/register datapath, e.g. to choose between a register-file operand and a ROM/immediate word.
- Selects `in1` when `sel`=1, else `in0`.
- Result is captured in an output register on the rising clock edge.
- A combinational bypass mode is available by parameter for datapath slots that cannot absorb a cycle of latency.

Parameters:
- WIDTH, 32, data width of `in0`, `in1` and `out`.
- REG_OUT, 1, 1 = output registered (1-cycle latency); 0 = purely combinational output (clock/reset unused).
- RESET_VAL, 0, value loaded into the output register on reset; truncated/zero-extended to WIDTH.

Ports:
- clk  input  1  system clock, rising-edge active
- rst  input  1  asynchronous, active-high reset
- in0  input  WIDTH  data source selected when `sel`=0
- in1  input  WIDTH  data source selected when `sel`=1
- sel  input  1  source select
- out  output  WIDTH  selected data

Behaviour:
- Interface: one clock (`clk`); reset `rst` is asynchronous and active-high.
- Select function: `next` = (`sel` == 1'b1) ? `in1` : `in0`.
  - Any `sel` value other than a clean 1 (0, X, Z) selects `in0`; the output is never X because of `sel`.
  - Bits pass unchanged: no sign handling, no arithmetic, bit i of `out` comes from bit i of the chosen input.
- REG_OUT=1:
  - `rst` rising sets `out` to RESET_VAL immediately, without waiting for a clock edge.
  - `out` holds RESET_VAL while `rst` is high, regardless of `clk`, `sel` or the data inputs.
  - On each rising `clk` with `rst` low: `out` <= `next`. Latency is exactly 1 cycle from `sel`/data change to `out`.
  - Reset deassertion: the first rising edge after `rst` falls loads `next`. No clock-ending glitch on `out` at deassertion itself.
  - Reset mid-operation: `out` drops to RESET_VAL asynchronously; the previous selection is lost.
  - `sel` and data changing in the same cycle: the value sampled at the edge is used; no intermediate value is visible.
  - Between edges `out` is stable; input toggles do not propagate.
- REG_OUT=0:
  - `out` = `next` combinationally, updating in the same delta as the inputs.
  - `rst` and `clk` are ignored; reset has no effect on `out`.
- No internal state other than the WIDTH-bit output register; no handshake; always ready.
- Synthesizable; no latches; the single register uses the async-reset template.

Test Plan:
- Reset: REG_OUT=1, `in0`=0, `in1`=32'hFFFFFFFF, `sel`=0, assert `rst` between clock edges -> `out`=0 immediately and held across 3 clock edges.
- Select in0: release `rst`, `sel`=0, `in0`=0, `in1`=32'hFFFFFFFF -> after 1st rising edge `out`=0 (monitor shows 0).
- Select in1: after ~100 ns set `sel`=1 -> `out` stays 0 until the next rising edge, then `out`=32'hFFFFFFFF (decimal 4294967295).
- Data tracking: `sel`=1, `in1` set to 32'h12345678 then 32'hDEADBEEF on consecutive cycles -> `out` follows each value with 1-cycle lag; `in0` toggling (32'hA5A5A5A5) has no effect.
- Async reset mid-stream: `out`=32'hFFFFFFFF, pulse `rst` for 3 ns between edges -> `out`=0 during the pulse; the next edge after release restores 32'hFFFFFFFF.
- Combinational variant: REG_OUT=0, toggle `sel` 0->1 with `in0`=0, `in1`=32'hFFFFFFFF and no clock -> `out` changes 0 -> 32'hFFFFFFFF with zero cycles of latency; `sel`=X -> `out`=0.

Source files
------------

// File: rtl/mux_2to1.sv
// -----------------------------------------------------------------------------
// mux_2to1
//
// Registered WIDTH-bit 2:1 data selector for the ROM/register datapath, e.g.
// choosing between a register-file operand and a ROM/immediate word.
//
// Ports:
//   clk  - system clock, rising-edge active (unused when REG_OUT = 0)
//   rst  - asynchronous, active-high reset (unused when REG_OUT = 0)
//   in0  - data source selected when sel is not a clean 1
//   in1  - data source selected when sel = 1
//   sel  - source select
//   out  - selected data; registered (1-cycle latency) or combinational
//
// Parameters:
//   WIDTH     - data width
//   REG_OUT   - 1: registered output, 0: combinational bypass
//   RESET_VAL - value loaded into the output register on reset
// -----------------------------------------------------------------------------
module mux_2to1 #(
    parameter int unsigned       WIDTH     = 32,
    parameter bit                REG_OUT   = 1'b1,
    parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic             sel,
    output logic [WIDTH-1:0] out
);

    logic [WIDTH-1:0] w_next;

    // An if-statement takes the else branch for X/Z, so anything other than a
    // clean 1 on sel selects in0 and sel alone can never put X on the output.
    always_comb begin
        w_next = in0;
        if (sel == 1'b1) begin
            w_next = in1;
        end
    end

    if (REG_OUT) begin : g_reg
        logic [WIDTH-1:0] r_out;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_out <= RESET_VAL;
            end else begin
                r_out <= w_next;
            end
        end

        assign out = r_out;
    end else begin : g_comb
        // Clock and reset are intentionally ignored in the bypass variant.
        logic w_unused_clk_rst;
        assign w_unused_clk_rst = clk ^ rst;

        assign out = w_next;
    end

endmodule

// File: tb/tb_mux_2to1.sv
// -----------------------------------------------------------------------------
// tb_mux_2to1
//
// Directed self-checking bench for mux_2to1: two registered instances (default
// reset value and a non-zero reset value) and one combinational instance.
// -----------------------------------------------------------------------------
module tb_mux_2to1;

    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [W-1:0] in0 = '0;
    logic [W-1:0] in1 = '1;
    logic         sel = 1'b0;
    logic [W-1:0] out_r;
    logic [W-1:0] out_rv;

    logic [W-1:0] in0_c = '0;
    logic [W-1:0] in1_c = '1;
    logic         sel_c = 1'b0;
    logic [W-1:0] out_c;
    logic [W-1:0] exp_c;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mux_2to1 #(.WIDTH(W), .REG_OUT(1'b1), .RESET_VAL(32'h0)) u_dut_reg (
        .clk (clk),
        .rst (rst),
        .in0 (in0),
        .in1 (in1),
        .sel (sel),
        .out (out_r)
    );

    mux_2to1 #(.WIDTH(W), .REG_OUT(1'b1), .RESET_VAL(32'h0000_00A5)) u_dut_rv (
        .clk (clk),
        .rst (rst),
        .in0 (in0),
        .in1 (in1),
        .sel (sel),
        .out (out_rv)
    );

    mux_2to1 #(.WIDTH(W), .REG_OUT(1'b0), .RESET_VAL(32'h0)) u_dut_comb (
        .clk (clk),
        .rst (rst),
        .in0 (in0_c),
        .in1 (in1_c),
        .sel (sel_c),
        .out (out_c)
    );

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Sample point: 1 ns after the next rising edge.
    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Load a known non-zero value so the reset drop is observable.
        @(negedge clk);
        sel = 1'b1;
        after_edge();
        check("preload", out_r, 32'hFFFF_FFFF);

        // Reset asserted between edges: output clears without a clock edge.
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_immediate", out_r, 32'h0);
        check("rst_immediate_rv", out_rv, 32'h0000_00A5);
        for (int i = 0; i < 3; i++) begin
            after_edge();
            check($sformatf("rst_hold%0d", i), out_r, 32'h0);
        end
        check("rst_hold_rv", out_rv, 32'h0000_00A5);

        // Release reset with sel=0; nothing changes until the next edge.
        @(negedge clk);
        rst = 1'b0;
        sel = 1'b0;
        #1;
        check("rst_release_no_glitch_rv", out_rv, 32'h0000_00A5);
        after_edge();
        check("sel_in0", out_r, 32'h0);
        check("sel_in0_rv", out_rv, 32'h0);

        // Select in1: held until the next edge.
        @(negedge clk);
        sel = 1'b1;
        #1;
        check("sel_in1_before_edge", out_r, 32'h0);
        after_edge();
        check("sel_in1", out_r, 32'hFFFF_FFFF);

        // Data tracking with in0 toggling underneath.
        @(negedge clk);
        in1 = 32'h1234_5678;
        in0 = 32'hA5A5_A5A5;
        #1;
        check("track_lag", out_r, 32'hFFFF_FFFF);
        after_edge();
        check("track_1", out_r, 32'h1234_5678);
        @(negedge clk);
        in1 = 32'hDEAD_BEEF;
        in0 = 32'h0;
        after_edge();
        check("track_2", out_r, 32'hDEAD_BEEF);

        // Mid-cycle input toggles do not reach a registered output.
        #2 in1 = 32'h0F0F_0F0F;
        #1 sel = 1'b0;
        #1;
        check("stable_between_edges", out_r, 32'hDEAD_BEEF);
        after_edge();
        check("sel_back_in0", out_r, 32'h0);

        // Async reset pulse mid-stream.
        @(negedge clk);
        sel = 1'b1;
        in1 = 32'hFFFF_FFFF;
        after_edge();
        check("pre_pulse", out_r, 32'hFFFF_FFFF);
        #2 rst = 1'b1;
        #1;
        check("pulse_clears", out_r, 32'h0);
        check("pulse_clears_rv", out_rv, 32'h0000_00A5);
        #2 rst = 1'b0;
        #1;
        check("pulse_released_before_edge", out_r, 32'h0);
        after_edge();
        check("pulse_restore", out_r, 32'hFFFF_FFFF);

        // Combinational variant: zero latency, no clock edge between change and check.
        sel_c = 1'b0;
        #1;
        check("comb_sel0", out_c, 32'h0);
        sel_c = 1'b1;
        #1;
        check("comb_sel1", out_c, 32'hFFFF_FFFF);
        in1_c = 32'h1234_5678;
        #1;
        check("comb_data", out_c, 32'h1234_5678);
        in0_c = 32'hCAFE_F00D;
        sel_c = 1'b0;
        #1;
        check("comb_in0_data", out_c, 32'hCAFE_F00D);
        rst = 1'b1;
        #1;
        check("comb_ignores_rst", out_c, 32'hCAFE_F00D);
        rst = 1'b0;
        in0_c = '0;
        in1_c = '1;
        sel_c = 1'bx;
        // In a 4-state simulator sel=X must pick in0; a 2-state one resolves X first.
        exp_c = (sel_c === 1'b1) ? in1_c : in0_c;
        #1;
        check("comb_sel_x", out_c, exp_c);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
